flash_sample_seq: RTL and testbench

Sequencer between the flash memory controller and the audio output path. It fetches one 32-bit word per flash address and splits it into two signed 16-bit samples. Each sample is presented on successive sample-rate ticks. After the word is consumed, it pulses the address counter's advance enable. Play/pause and direction come from the same user controls that drive the address counter.

---
 rtl/flash_sample_seq.sv | 196 +++++++++++++++++++
 tb/tb_flash_sample_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_sample_seq.sv
// flash_sample_seq
//   Sits between the flash controller and the audio output path. On each
//   qualifying sample tick it fetches one 32-bit word from flash at the
//   address counter's current address. It then presents the word as two
//   signed 16-bit samples on successive ticks. After the second half it
//   pulses addr_adv so the address counter moves on.
//
// Optional build macro: READ_TIMEOUT_EN
//   Defined   : a watchdog bounds the time spent in REQ/WAIT. On expiry the
//               read is abandoned, the sticky o_rd_err flag is set, a zero
//               sample is emitted, and the bad word is skipped.
//   Undefined : REQ/WAIT wait indefinitely and o_rd_err is tied to 0.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   i_sample_tick         : one-cycle strobe at the audio sample rate
//   i_playpause           : 1 = play, 0 = pause
//   i_dir                 : 1 = forward (low half first), 0 = reverse
//   i_addr[22:0]          : word address from the address counter
//   o_flash_read          : read request (held high through waitrequest)
//   o_flash_address[22:0] : read address, latched when the fetch starts
//   o_flash_byteenable    : constant 4'b1111
//   i_flash_waitrequest   : controller stall
//   i_flash_readdata[31:0]: returned word
//   i_flash_readdatavalid : qualifier for i_flash_readdata
//   o_addr_adv            : one-cycle pulse after a word is consumed
//   o_sample[15:0]        : current signed audio sample (held between updates)
//   o_sample_valid        : one-cycle pulse when o_sample updates
//   o_rd_err              : sticky read-timeout flag
module flash_sample_seq #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sample_tick,
  input  logic        i_playpause,
  input  logic        i_dir,
  input  logic [22:0] i_addr,
  output logic        o_flash_read,
  output logic [22:0] o_flash_address,
  output logic [3:0]  o_flash_byteenable,
  input  logic        i_flash_waitrequest,
  input  logic [31:0] i_flash_readdata,
  input  logic        i_flash_readdatavalid,
  output logic        o_addr_adv,
  output logic [15:0] o_sample,
  output logic        o_sample_valid,
  output logic        o_rd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FIRST,
    S_HOLD,
    S_SECOND
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("flash_sample_seq: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      r_state, w_state_next;
  logic [22:0] r_addr, w_addr_next;
  logic [31:0] r_word, w_word_next;
  logic        r_word_dir, w_word_dir_next;
  logic [15:0] r_sample, w_sample_next;
  logic        r_sample_valid, w_sample_valid_next;
  logic        r_addr_adv, w_addr_adv_next;
  logic        w_timeout;
  logic        w_tick_play;

  assign w_tick_play        = i_sample_tick & i_playpause;
  assign o_flash_address    = r_addr;
  assign o_flash_byteenable = 4'b1111;
  assign o_sample           = r_sample;
  assign o_sample_valid     = r_sample_valid;
  assign o_addr_adv         = r_addr_adv;

`ifdef READ_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0] r_to_cnt;
  logic          r_rd_err;

  // The counter reads 0 in the first REQ cycle, so the last cycle spent
  // waiting is the TIMEOUT_CYCLES-th one.
  assign w_timeout = ((r_state == S_REQ) || (r_state == S_WAIT)) &&
                     (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign o_rd_err  = r_rd_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_rd_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_state_next == S_REQ)
        r_to_cnt <= '0;
      else if (r_state == S_REQ || r_state == S_WAIT)
        r_to_cnt <= r_to_cnt + 1'b1;
      if (w_timeout)
        r_rd_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign o_rd_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_word         <= '0;
      r_word_dir     <= 1'b0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_addr_adv     <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_addr         <= w_addr_next;
      r_word         <= w_word_next;
      r_word_dir     <= w_word_dir_next;
      r_sample       <= w_sample_next;
      r_sample_valid <= w_sample_valid_next;
      r_addr_adv     <= w_addr_adv_next;
    end
  end

  // Sample/valid/adv are registered, so each is computed on the transition
  // into the state that presents it (FIRST, SECOND, or IDLE after timeout).
  always_comb begin
    w_state_next        = r_state;
    w_addr_next         = r_addr;
    w_word_next         = r_word;
    w_word_dir_next     = r_word_dir;
    w_sample_next       = r_sample;
    w_sample_valid_next = 1'b0;
    w_addr_adv_next     = 1'b0;
    o_flash_read        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_tick_play) begin
          w_state_next = S_REQ;
          w_addr_next  = i_addr;
        end
      end
      S_REQ: begin
        o_flash_read = 1'b1;
        if (w_timeout) begin
          w_state_next        = S_IDLE;
          w_sample_next       = '0;
          w_sample_valid_next = 1'b1;
          w_addr_adv_next     = 1'b1;
        end else if (!i_flash_waitrequest) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // Returned data wins over a timeout expiring in the same cycle.
        if (i_flash_readdatavalid) begin
          w_state_next        = S_FIRST;
          w_word_next         = i_flash_readdata;
          w_word_dir_next     = i_dir;
          w_sample_next       = i_dir ? i_flash_readdata[15:0] : i_flash_readdata[31:16];
          w_sample_valid_next = 1'b1;
        end else if (w_timeout) begin
          w_state_next        = S_IDLE;
          w_sample_next       = '0;
          w_sample_valid_next = 1'b1;
          w_addr_adv_next     = 1'b1;
        end
      end
      S_FIRST: begin
        w_state_next = S_HOLD;
      end
      S_HOLD: begin
        if (w_tick_play) begin
          w_state_next        = S_SECOND;
          w_sample_next       = r_word_dir ? r_word[31:16] : r_word[15:0];
          w_sample_valid_next = 1'b1;
          w_addr_adv_next     = 1'b1;
        end
      end
      S_SECOND: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_flash_sample_seq.sv
// Directed bench for flash_sample_seq. Expected samples are pushed to a
// scoreboard when the stimulus is driven; a monitor pops and compares them
// whenever the DUT pulses sample_valid. Timing is checked inline.
module tb_flash_sample_seq;

  localparam int TO_CYC = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_sample_tick;
  logic        i_playpause;
  logic        i_dir;
  logic [22:0] i_addr;
  logic        o_flash_read;
  logic [22:0] o_flash_address;
  logic [3:0]  o_flash_byteenable;
  logic        i_flash_waitrequest;
  logic [31:0] i_flash_readdata;
  logic        i_flash_readdatavalid;
  logic        o_addr_adv;
  logic [15:0] o_sample;
  logic        o_sample_valid;
  logic        o_rd_err;

  typedef struct {
    logic [15:0] s;
    logic        adv;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  flash_sample_seq #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_sample_tick         (i_sample_tick),
    .i_playpause           (i_playpause),
    .i_dir                 (i_dir),
    .i_addr                (i_addr),
    .o_flash_read          (o_flash_read),
    .o_flash_address       (o_flash_address),
    .o_flash_byteenable    (o_flash_byteenable),
    .i_flash_waitrequest   (i_flash_waitrequest),
    .i_flash_readdata      (i_flash_readdata),
    .i_flash_readdatavalid (i_flash_readdatavalid),
    .o_addr_adv            (o_addr_adv),
    .o_sample              (o_sample),
    .o_sample_valid        (o_sample_valid),
    .o_rd_err              (o_rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [15:0] s, input logic adv);
    exp_t e;
    e.s   = s;
    e.adv = adv;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: one line per delivered sample.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_sample_valid) begin
        chk("valid_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          $display("sample txn: sample=%04h adv=%0b (exp %04h/%0b)", o_sample, o_addr_adv, e.s, e.adv);
          chk("sample", 32'(o_sample), 32'(e.s));
          chk("addr_adv", 32'(o_addr_adv), 32'(e.adv));
        end
      end else begin
        chk("adv_without_valid", 32'(o_addr_adv), 32'd0);
      end
      chk("byteenable", 32'(o_flash_byteenable), 32'hF);
    end
  end

  // Fetch a word and check its first sample appears one cycle after readdatavalid.
  task automatic do_fetch(input logic [22:0] a, input logic d, input logic [31:0] w,
                          input int nwait, input int nlat);
    i_sample_tick = 1'b1;
    i_playpause   = 1'b1;
    i_dir         = d;
    i_addr        = a;
    push_exp(d ? w[15:0] : w[31:16], 1'b0);
    @(negedge clk);
    i_sample_tick = 1'b0;
    for (int i = 0; i <= nwait; i++) begin
      chk("req_read", 32'(o_flash_read), 32'd1);
      chk("req_addr", 32'(o_flash_address), 32'(a));
      i_flash_waitrequest = (i != nwait);
      // a tick during the stall must be dropped
      i_sample_tick = (i == 0 && nwait > 0);
      @(negedge clk);
      i_sample_tick = 1'b0;
    end
    i_flash_waitrequest = 1'b0;
    for (int i = 1; i < nlat; i++) begin
      chk("wait_read_low", 32'(o_flash_read), 32'd0);
      @(negedge clk);
    end
    chk("wait_read_low", 32'(o_flash_read), 32'd0);
    i_flash_readdatavalid = 1'b1;
    i_flash_readdata      = w;
    @(negedge clk);
    i_flash_readdatavalid = 1'b0;
    i_flash_readdata      = 32'h0;
    i_dir                 = ~d;   // mid-word change must not matter
    chk("first_valid_timing", 32'(o_sample_valid), 32'd1);
  endtask

  // Deliver the second half, optionally with paused ticks in HOLD first.
  task automatic second_half(input logic [15:0] first_s, input logic [15:0] second_s,
                             input int pause_ticks);
    @(negedge clk);
    @(negedge clk);
    if (pause_ticks > 0) begin
      i_playpause = 1'b0;
      for (int i = 0; i < pause_ticks; i++) begin
        i_sample_tick = 1'b1;
        @(negedge clk);
        i_sample_tick = 1'b0;
        chk("pause_no_valid", 32'(o_sample_valid), 32'd0);
        chk("pause_frozen", 32'(o_sample), 32'(first_s));
        @(negedge clk);
      end
      i_playpause = 1'b1;
    end
    push_exp(second_s, 1'b1);
    i_sample_tick = 1'b1;
    @(negedge clk);
    i_sample_tick = 1'b0;
    chk("second_valid_timing", 32'(o_sample_valid), 32'd1);
    chk("second_adv_timing", 32'(o_addr_adv), 32'd1);
    @(negedge clk);
    chk("hold_after_second", 32'(o_sample), 32'(second_s));
  endtask

  initial begin
    rst                   = 1'b1;
    i_sample_tick         = 1'b0;
    i_playpause           = 1'b0;
    i_dir                 = 1'b1;
    i_addr                = 23'h0;
    i_flash_waitrequest   = 1'b0;
    i_flash_readdata      = 32'h0;
    i_flash_readdatavalid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_read", 32'(o_flash_read), 32'd0);
    chk("rst_addr", 32'(o_flash_address), 32'd0);
    chk("rst_sample", 32'(o_sample), 32'd0);
    chk("rst_valid", 32'(o_sample_valid), 32'd0);
    chk("rst_adv", 32'(o_addr_adv), 32'd0);
    chk("rst_err", 32'(o_rd_err), 32'd0);

    // ticks while paused in IDLE are ignored
    i_sample_tick = 1'b1;
    @(negedge clk);
    i_sample_tick = 1'b0;
    @(negedge clk);
    chk("pause_idle_no_read", 32'(o_flash_read), 32'd0);

    // forward, zero wait
    do_fetch(23'h000010, 1'b1, 32'hABCD1234, 0, 1);
    second_half(16'h1234, 16'hABCD, 0);
    // reverse, zero wait
    do_fetch(23'h000011, 1'b0, 32'hABCD1234, 0, 1);
    second_half(16'hABCD, 16'h1234, 0);
    // stall 5 cycles, data 4 cycles after acceptance
    do_fetch(23'h2A5A5A, 1'b1, 32'h8001_7FFF, 5, 4);
    second_half(16'h7FFF, 16'h8001, 0);
    // pause across 3 ticks in HOLD
    do_fetch(23'h7FFFFF, 1'b0, 32'h1357_9BDF, 1, 2);
    second_half(16'h1357, 16'h9BDF, 3);

    // reset during WAIT, then late readdatavalid in IDLE
    i_sample_tick = 1'b1;
    i_playpause   = 1'b1;
    i_addr        = 23'h000123;
    @(negedge clk);
    i_sample_tick = 1'b0;
    chk("rstwait_req", 32'(o_flash_read), 32'd1);
    @(negedge clk);
    chk("rstwait_in_wait", 32'(o_flash_read), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_read", 32'(o_flash_read), 32'd0);
    chk("rstmid_addr", 32'(o_flash_address), 32'd0);
    chk("rstmid_sample", 32'(o_sample), 32'd0);
    i_playpause           = 1'b0;
    i_flash_readdatavalid = 1'b1;
    i_flash_readdata      = 32'hDEADBEEF;
    @(negedge clk);
    i_flash_readdatavalid = 1'b0;
    chk("late_rdv_sample", 32'(o_sample), 32'd0);
    chk("late_rdv_valid", 32'(o_sample_valid), 32'd0);
    @(negedge clk);
    chk("late_rdv_read", 32'(o_flash_read), 32'd0);

`ifdef READ_TIMEOUT_EN
    begin
      int cyc;
      i_sample_tick = 1'b1;
      i_playpause   = 1'b1;
      i_addr        = 23'h000040;
      push_exp(16'h0000, 1'b1);
      cyc = 0;
      while (!o_sample_valid && cyc < 100) begin
        @(negedge clk);
        i_sample_tick = 1'b0;
        cyc++;
      end
      chk("timeout_latency", 32'(cyc), 32'(TO_CYC + 1));
      chk("timeout_err", 32'(o_rd_err), 32'd1);
      chk("timeout_read_low", 32'(o_flash_read), 32'd0);
      chk("timeout_sample", 32'(o_sample), 32'd0);
      @(negedge clk);
      do_fetch(23'h000041, 1'b1, 32'h5555AAAA, 0, 1);
      second_half(16'hAAAA, 16'h5555, 0);
      chk("err_sticky", 32'(o_rd_err), 32'd1);
    end
`else
    chk("err_tied_low", 32'(o_rd_err), 32'd0);
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
